// File: rtl/error_frame_tx_pkg.sv
// Shared CAN definitions: error/overload frame states, frame kinds, bus levels
// and default frame lengths.
`timescale 1ns/1ps
package error_frame_tx_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLAG     = 2'd1,
      WAIT_REC = 2'd2,
      DELIM    = 2'd3
   } frame_state_e;

   typedef enum logic {
      ERROR    = 1'b0,
      OVERLOAD = 1'b1
   } frame_kind_e;

   localparam logic CAN_DOMINANT  = 1'b0;
   localparam logic CAN_RECESSIVE = 1'b1;

   localparam int DEF_FLAG_LEN  = 6;
   localparam int DEF_DELIM_LEN = 8;
   localparam int DEF_DOM_LIMIT = 14;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/error_frame_tx.sv
// CAN error/overload frame transmitter: drives the flag, waits for a recessive
// bus, then checks the recessive delimiter before handing back to interframe.
`timescale 1ns/1ps
module error_frame_tx
   import error_frame_tx_pkg::*;
#(
   parameter int FLAG_LEN  = DEF_FLAG_LEN,
   parameter int DELIM_LEN = DEF_DELIM_LEN,
   parameter int DOM_LIMIT = DEF_DOM_LIMIT
) (
   input  logic clock,
   input  logic reset,
   input  logic samplePoint,
   input  logic rxBit,
   input  logic erro,
   input  logic overloadFlag,
   input  logic errorPassive,
   output logic txBit,
   output logic busy,
   output logic interframe,
   output logic formErro,
   output logic stuckErro
);

   localparam int CNT_W = $clog2(max3(FLAG_LEN, DELIM_LEN, DOM_LIMIT) + 1);
   localparam logic [CNT_W-1:0] FLAG_LAST  = CNT_W'(FLAG_LEN - 1);
   localparam logic [CNT_W-1:0] DELIM_LAST = CNT_W'(DELIM_LEN - 1);
   localparam logic [CNT_W-1:0] DOM_LAST   = CNT_W'(DOM_LIMIT - 1);

   frame_state_e     state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] dom_cnt_q;
   logic             tx_q;
   logic             busy_q;
   logic             interframe_q;
   logic             form_erro_q;
   logic             stuck_erro_q;

   frame_kind_e      req_kind;
   logic             req_passive;

   // Only error frames may be passive; an overload flag is always dominant.
   always_comb begin
      req_kind    = erro ? ERROR : OVERLOAD;
      req_passive = (req_kind == ERROR) && errorPassive;
   end

   always_ff @(posedge clock) begin
      // NOTE: state is written with non-blocking assignments so every branch
      // below sees the pre-edge values; the pulse defaults are overridden later.
      interframe_q <= 1'b0;
      form_erro_q  <= 1'b0;
      stuck_erro_q <= 1'b0;
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         dom_cnt_q <= '0;
         tx_q      <= CAN_RECESSIVE;
         busy_q    <= 1'b0;
      end else if (samplePoint) begin
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (erro || overloadFlag) begin
                  state_q <= FLAG;
                  tx_q    <= req_passive ? CAN_RECESSIVE : CAN_DOMINANT;
                  busy_q  <= 1'b1;
               end
            end
            FLAG: begin
               if (cnt_q == FLAG_LAST) begin
                  state_q   <= WAIT_REC;
                  tx_q      <= CAN_RECESSIVE;
                  cnt_q     <= '0;
                  dom_cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WAIT_REC: begin
               // The first recessive bit already counts as delimiter bit 1.
               if (rxBit == CAN_RECESSIVE) begin
                  state_q   <= DELIM;
                  cnt_q     <= CNT_W'(1);
                  dom_cnt_q <= '0;
               end else if (dom_cnt_q == DOM_LAST) begin
                  stuck_erro_q <= 1'b1;
                  dom_cnt_q    <= '0;
               end else begin
                  dom_cnt_q <= dom_cnt_q + 1'b1;
               end
            end
            DELIM: begin
               if (rxBit == CAN_RECESSIVE) begin
                  if (cnt_q == DELIM_LAST) begin
                     state_q      <= IDLE;
                     busy_q       <= 1'b0;
                     cnt_q        <= '0;
                     interframe_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else begin
                  state_q     <= FLAG;
                  cnt_q       <= '0;
                  tx_q        <= errorPassive ? CAN_RECESSIVE : CAN_DOMINANT;
                  form_erro_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign txBit      = tx_q;
   assign busy       = busy_q;
   assign interframe = interframe_q;
   assign formErro   = form_erro_q;
   assign stuckErro  = stuck_erro_q;

endmodule

// File: tb/tb_error_frame_tx.sv
// Scoreboard bench for error_frame_tx: a bit-level frame model predicts the
// outputs after every sample edge; a monitor compares them as the DUT updates.
`timescale 1ns/1ps
module tb_error_frame_tx;

   localparam int FLAG_LEN  = 6;
   localparam int DELIM_LEN = 8;
   localparam int DOM_LIMIT = 14;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic samplePoint = 1'b0;
   logic rxBit = 1'b1;
   logic erro = 1'b0;
   logic overloadFlag = 1'b0;
   logic errorPassive = 1'b0;
   logic txBit, busy, interframe, formErro, stuckErro;

   typedef struct packed {
      logic tx;
      logic busy;
      logic intf;
      logic form;
      logic stuck;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 1'b0;

   // Frame model: where we are in the frame, expressed as remaining flag bits
   // and runs of recessive / dominant bits seen after the flag.
   bit m_busy    = 1'b0;
   bit m_tx      = 1'b1;
   int flag_left = 0;
   int rec_run   = 0;
   int dom_run   = 0;

   always #5 clock = ~clock;

   error_frame_tx dut (
      .clock        (clock),
      .reset        (reset),
      .samplePoint  (samplePoint),
      .rxBit        (rxBit),
      .erro         (erro),
      .overloadFlag (overloadFlag),
      .errorPassive (errorPassive),
      .txBit        (txBit),
      .busy         (busy),
      .interframe   (interframe),
      .formErro     (formErro),
      .stuckErro    (stuckErro)
   );

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: {tx,busy,intf,form,stuck} got %b expected %b",
                  name, $time, act, req);
      end
   endtask

   task automatic model_step(input logic rx, input logic e, input logic o,
                             input logic ep, output exp_t x);
      x = '0;
      if (!m_busy) begin
         if (e || o) begin
            m_busy    = 1'b1;
            flag_left = FLAG_LEN;
            rec_run   = 0;
            m_tx      = e & ep;
         end
      end else if (flag_left > 0) begin
         flag_left--;
         if (flag_left == 0) begin
            m_tx    = 1'b1;
            dom_run = 0;
         end
      end else if (rec_run == 0) begin
         if (rx) begin
            rec_run = 1;
         end else begin
            dom_run++;
            if (dom_run == DOM_LIMIT) begin
               x.stuck = 1'b1;
               dom_run = 0;
            end
         end
      end else if (rx) begin
         rec_run++;
         if (rec_run == DELIM_LEN) begin
            x.intf = 1'b1;
            m_busy = 1'b0;
         end
      end else begin
         x.form    = 1'b1;
         flag_left = FLAG_LEN;
         rec_run   = 0;
         m_tx      = ep;
      end
      x.tx   = m_tx;
      x.busy = m_busy;
   endtask

   // One bit time: a sample strobe then three quiet clocks. The bus is the
   // wired-AND of our own (modelled) drive and any other node pulling dominant.
   task automatic do_bit(input logic other_dom, input logic e, input logic o, input logic ep);
      exp_t x;
      @(negedge clock);
      samplePoint  = 1'b1;
      rxBit        = m_tx & ~other_dom;
      erro         = e;
      overloadFlag = o;
      errorPassive = ep;
      model_step(rxBit, e, o, ep, x);
      exp_q.push_back(x);
      @(negedge clock);
      samplePoint = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   // Reset lands on a sample edge with a pending request; reset must win.
   task automatic do_reset();
      exp_t x;
      @(negedge clock);
      reset       = 1'b0;
      samplePoint = 1'b1;
      erro        = 1'b1;
      rxBit       = 1'b1;
      m_busy = 1'b0; m_tx = 1'b1; flag_left = 0; rec_run = 0; dom_run = 0;
      x = 5'b10000;
      exp_q.push_back(x);
      mon_en = 1'b1;
      @(negedge clock);
      reset       = 1'b1;
      samplePoint = 1'b0;
      erro        = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic run_frame(input logic e, input logic o, input logic ep,
                            input int dom_from, input int dom_to, input int nbits);
      for (int i = 0; i < nbits; i++)
         do_bit((i >= dom_from) && (i <= dom_to), (i == 0) ? e : 1'b0,
                (i == 0) ? o : 1'b0, ep);
   endtask

   // Monitor: sample edges and reset edges consume one expectation; every other
   // edge must leave txBit/busy unchanged and all pulses low.
   initial begin
      exp_t e;
      exp_t last;
      last = 5'b10000;
      forever begin
         @(posedge clock);
         if (mon_en) begin
            if (samplePoint || !reset) begin
               #1;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL scoreboard_empty at %0t: got no expectation, required one", $time);
               end else begin
                  e = exp_q.pop_front();
                  check("edge_outputs", {txBit, busy, interframe, formErro, stuckErro}, e);
                  last = e;
               end
            end else begin
               #1;
               check("hold_outputs", {txBit, busy, interframe, formErro, stuckErro},
                     {last.tx, last.busy, 3'b000});
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clock);
      do_reset();

      run_frame(1'b1, 1'b0, 1'b0, -1, -1, 16);   // active error, clean bus
      run_frame(1'b1, 1'b0, 1'b0, 1, 9, 20);     // flag superposition, 3 extra dominant
      run_frame(1'b1, 1'b0, 1'b0, 11, 11, 28);   // dominant at delimiter bit 5
      run_frame(1'b1, 1'b0, 1'b0, 7, 36, 47);    // stuck dominant for 30 bits
      run_frame(1'b1, 1'b0, 1'b1, -1, -1, 16);   // passive error
      run_frame(1'b1, 1'b1, 1'b1, -1, -1, 16);   // both requests: error wins

      run_frame(1'b0, 1'b1, 1'b0, -1, -1, 4);    // overload, reset at flag bit 3
      do_reset();
      run_frame(1'b0, 1'b1, 1'b0, -1, -1, 16);   // fresh overload frame

      for (int i = 0; i < 32; i++)               // request held: back-to-back frames
         do_bit(1'b0, 1'b1, 1'b0, 1'b0);
      run_frame(1'b0, 1'b0, 1'b0, -1, -1, 16);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 149) == 0)
            do_reset();
         else
            do_bit($urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
      end

      repeat (4) @(negedge clock);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/error_frame_tx.md
# error_frame_tx

Transmit side of CAN error/overload signalling. Once an error or overload condition has been detected and flagged, this block generates the corresponding frame on the bus: the error or overload flag, then the wait for a recessive bus, then the 8-bit recessive delimiter. It sits between the error/overload detection logic (`erro`, `overloadFlag`) and the bit-level bus driver. Its `interframe` pulse hands the bus back to interframe-space logic.

## Interface
- `FLAG_LEN`, 6, bit times of the error/overload flag.
- `DELIM_LEN`, 8, recessive bit times of the delimiter, including the first recessive bit seen after the flag.
- `DOM_LIMIT`, 14, consecutive dominant bits tolerated while waiting for recessive before `stuckErro` fires.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `samplePoint`  in  1  one-cycle strobe per bit time; state advances only on cycles where it is 1.
- `rxBit`  in  1  bus value sampled at the sample point (0 = dominant).
- `erro`  in  1  error frame request, sampled at `samplePoint`.
- `overloadFlag`  in  1  overload frame request, sampled at `samplePoint`.
- `errorPassive`  in  1  node is error-passive; captured when an error request is accepted.
- `txBit`  out  1  bit to drive on the bus (0 = dominant).
- `busy`  out  1  a frame is in progress.
- `interframe`  out  1  one-cycle pulse when the delimiter completes.
- `formErro`  out  1  one-cycle pulse: dominant bit sampled during the delimiter.
- `stuckErro`  out  1  one-cycle pulse: `DOM_LIMIT` consecutive dominant bits sampled in WAIT_REC.

## Operation
- States: IDLE, FLAG, WAIT_REC, DELIM. Every transition happens on a clock edge where `samplePoint`=1.
- **IDLE**
  - If `erro`=1: go to FLAG with kind=ERROR and `passive`=`errorPassive`.
  - Else if `overloadFlag`=1: go to FLAG with kind=OVERLOAD and `passive`=0.
  - Bit counter `cnt` is cleared to 0.
  - `erro` has priority when both requests are high.
- **FLAG**
  - `txBit`=0 for active flags and 1 for passive flags.
  - `cnt` increments once per sample point.
  - After `FLAG_LEN` sample points spent in FLAG: go to WAIT_REC with `txBit`=1 and `domCnt`=0.
  - `rxBit` is ignored, so flag superposition by other nodes is allowed.
- **WAIT_REC**
  - `rxBit`=1: go to DELIM with `cnt`=1.
  - `rxBit`=0: increment `domCnt`. When `domCnt` reaches `DOM_LIMIT`, pulse `stuckErro` and reset `domCnt` to 0, staying in WAIT_REC.
- **DELIM** (`txBit`=1)
  - `rxBit`=1: increment `cnt`. When `cnt` reaches `DELIM_LEN`, pulse `interframe` and go to IDLE.
  - `rxBit`=0: pulse `formErro`, then go to FLAG with kind=ERROR, `passive`=`errorPassive` and `cnt`=0.
- Requests seen while not in IDLE are ignored and not queued; the requester must hold them.
- `busy`=1 in every state except IDLE.
- Reset values: `txBit`=1, `busy`=0, `interframe`=0, `formErro`=0, `stuckErro`=0, state IDLE, counters 0.
- Reset mid-frame: the bus is released to recessive on the same edge and no pulses are emitted.
- Counter width: clog2(max(`FLAG_LEN`, `DELIM_LEN`, `DOM_LIMIT`)+1) bits. Counters never wrap, because each one is cleared on the transition out of its state.

## Timing
- All outputs are registered.
- `txBit` takes its new value in the cycle after the accepting `samplePoint` edge, and holds until the next transition.
- For an active error flag, `txBit`=0 for exactly `FLAG_LEN` bit times.
- Minimum frame with a clean bus: `FLAG_LEN` + `DELIM_LEN` sample points from acceptance to the `interframe` pulse (14 with defaults).
- `interframe`, `formErro` and `stuckErro` are each high for exactly one clock and coincide with the state change.
- Back-to-back frames: a request held high through the `interframe` edge is accepted at the next sample point, not the same one.

## Structure
- Shared CAN package holds:
  - the state enum (IDLE, FLAG, WAIT_REC, DELIM);
  - the frame-kind enum (ERROR, OVERLOAD);
  - constants `CAN_DOMINANT`=0 and `CAN_RECESSIVE`=1;
  - the default lengths 6, 8 and 14.
- Single module, no sub-modules. The bit counter is inline.

## Test plan
- Active error, clean bus: pulse `erro` at one sample point with `rxBit` following `txBit` → 6 dominant bits, then 8 recessive, then a single `interframe` pulse at sample point 14; `busy` falls on the same edge.
- Superposition: another node holds dominant for 3 extra bits after our flag → 3 bits in WAIT_REC, then the delimiter, then `interframe` at sample point 17; no error pulses.
- Dominant in delimiter: drive `rxBit`=0 at delimiter bit 5 → one `formErro` pulse, then a new 6-bit active flag.
- Stuck bus: hold `rxBit`=0 for 30 bits after the flag → `stuckErro` pulses at dominant bits 14 and 28; the block stays in WAIT_REC.
- Passive and priority:
  - `erro` with `errorPassive`=1 → `txBit` stays 1 for the whole frame and `interframe` arrives at sample point 14.
  - `erro` and `overloadFlag` high together → kind=ERROR.
- Reset: assert `reset`=0 at flag bit 3 → on the next edge `txBit`=1 and `busy`=0 with no pulses; after release, a new `overloadFlag` starts a fresh 6-bit flag.
